// File: rtl/winocnn_mem_pkg.sv
// rtl/winocnn_mem_pkg.sv - shared scan-memory types and default sizes
package winocnn_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  localparam int WORD_WIDTH_D = 512;
  localparam int NUM_ROWS_D   = 128;
  localparam int ROW_ADDR_W   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       update_en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] ptr
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] gidx;
  logic             found;

  // Search upward from the pointer, wrapping, and take the first requester.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        gidx  = PTR_W'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (update_en && found) begin
      ptr <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_scan_scheduler.sv
// rtl/mem_scan_scheduler.sv - round-robin burst scheduler for the shared scan memory
module mem_scan_scheduler
  import winocnn_mem_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_D,
  parameter int NUM_ROWS   = NUM_ROWS_D,
  parameter int ADDR_WIDTH = ROW_ADDR_W,
  parameter int NUM_REQ    = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_start_row,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_last_row,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               mem_scan_en,
  output logic [ADDR_WIDTH-1:0]              mem_row,
  input  logic [WORD_WIDTH-1:0]              mem_data_in,
  output logic [WORD_WIDTH-1:0]              rd_data,
  output logic [NUM_REQ-1:0]                 rd_valid,
  output logic                               rd_last,
  output logic                               busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] MAX_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

  scan_state_t             state;
  logic                    idle;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      grant_q;
  logic [PTR_W-1:0]        rr_ptr;
  logic [ADDR_WIDTH-1:0]   sel_start;
  logic [ADDR_WIDTH-1:0]   sel_last;
  logic [ADDR_WIDTH-1:0]   clamp_last;
  logic [ADDR_WIDTH-1:0]   cur_row;
  logic [ADDR_WIDTH-1:0]   last_row;
  logic                    pipe_valid;
  logic                    pipe_last;
  logic [NUM_REQ-1:0]      pipe_grant;

  assign idle = (state == ST_IDLE);

  // Requests are masked outside IDLE so the grant doubles as req_ready.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid & {NUM_REQ{idle}}),
    .update_en (idle),
    .grant     (grant),
    .ptr       (rr_ptr)
  );

  assign req_ready = grant;

  always_comb begin
    sel_start = '0;
    sel_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_start = sel_start | req_start_row[i];
        sel_last  = sel_last  | req_last_row[i];
      end
    end
  end

  // Clip to the memory, then collapse an inverted range to the start row.
  always_comb begin
    clamp_last = (sel_last > MAX_ROW) ? MAX_ROW : sel_last;
    if (clamp_last < sel_start) begin
      clamp_last = sel_start;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_q  <= '0;
      cur_row  <= '0;
      last_row <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            grant_q  <= grant;
            cur_row  <= sel_start;
            last_row <= clamp_last;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_row == last_row) begin
            state <= ST_DRAIN;
          end else begin
            cur_row <= cur_row + 1'b1;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign mem_scan_en = (state == ST_SCAN);
  assign mem_row     = mem_scan_en ? cur_row : '0;
  assign busy        = !idle;

  // Tag pipe lines up with the one-cycle memory read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_last  <= 1'b0;
      pipe_grant <= '0;
    end else begin
      pipe_valid <= mem_scan_en;
      pipe_last  <= mem_scan_en && (cur_row == last_row);
      pipe_grant <= grant_q;
    end
  end

  assign rd_data  = mem_data_in;
  assign rd_valid = pipe_valid ? pipe_grant : '0;
  assign rd_last  = pipe_last;

  a_start_in_range: assert property (@(posedge clock) disable iff (reset)
    (|req_ready) |-> (32'(sel_start) < NUM_ROWS));
  a_ptr_in_range: assert property (@(posedge clock) disable iff (reset)
    32'(rr_ptr) < NUM_REQ);

endmodule
